// File: rtl/instruction_prefetch_queue.sv
// Sequential instruction fetch front end: one outstanding memory request,
// fetched words buffered with PC+4 in a small FIFO ahead of IF/ID.
module instruction_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clock,
  input  logic                   reset,
  output logic                   imem_req,
  output logic [31:0]            imem_addr,
  input  logic                   imem_ack,
  input  logic [31:0]            imem_rdata,
  input  logic                   redirect,
  input  logic [31:0]            redirect_pc,
  output logic                   out_valid,
  output logic [31:0]            out_instruction,
  output logic [31:0]            out_pc_plus_four,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic                   state_dbg
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // Handshakes: a memory transfer happens on a rising edge with
  // imem_req && imem_ack, and imem_req/imem_addr never change while waiting;
  // a head entry is consumed on a rising edge with out_valid && out_ready.
  typedef enum logic { S_FETCH = 1'b0, S_DISCARD = 1'b1 } state_t;

  state_t        state_q, state_d;
  logic [31:0]   fetch_pc, target_q, redirect_target;
  logic          req_q;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [31:0]   mem_instr [DEPTH];
  logic [31:0]   mem_pc4   [DEPTH];
  logic          xfer, push, pop;
  logic          latch_target, pc_from_redirect, pc_from_target;

  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // DISCARD means the in-flight word belongs to a path that was redirected away.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:   if (redirect && req_q && !imem_ack) state_d = S_DISCARD;
      S_DISCARD: if (imem_ack) state_d = S_FETCH;
    endcase
  end

  always_comb begin
    xfer             = req_q && imem_ack;
    pop              = out_valid && out_ready && !redirect;
    push             = 1'b0;
    latch_target     = 1'b0;
    pc_from_redirect = 1'b0;
    pc_from_target   = 1'b0;
    case (state_q)
      S_FETCH: begin
        push             = xfer && !redirect;
        pc_from_redirect = redirect && (!req_q || imem_ack);
        latch_target     = redirect && req_q && !imem_ack;
      end
      S_DISCARD: begin
        pc_from_redirect = redirect && xfer;
        pc_from_target   = !redirect && xfer;
        latch_target     = redirect && !xfer;
      end
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (redirect)          count_d = '0;
    else if (push && !pop) count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  // Space is checked only when (re)arming the request, so an armed request
  // always has a free slot to land in.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      target_q <= '0;
      req_q    <= 1'b0;
      count_q  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      count_q <= count_d;
      if (!req_q || xfer) req_q <= (count_d < FULL);
      if (pc_from_redirect)    fetch_pc <= redirect_target;
      else if (pc_from_target) fetch_pc <= target_q;
      else if (push)           fetch_pc <= fetch_pc + 32'd4;
      if (latch_target) target_q <= redirect_target;
      if (redirect) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_instr[i] <= '0;
        mem_pc4[i]   <= '0;
      end
    end else if (push) begin
      mem_instr[wr_ptr] <= imem_rdata;
      mem_pc4[wr_ptr]   <= fetch_pc + 32'd4;
    end
  end

  assign imem_req         = req_q;
  assign imem_addr        = fetch_pc;
  assign out_valid        = (count_q != '0);
  assign out_instruction  = mem_instr[rd_ptr];
  assign out_pc_plus_four = mem_pc4[rd_ptr];
  assign occupancy        = count_q;
  assign state_dbg        = (state_q == S_DISCARD);
endmodule

// File: tb/tb_instruction_prefetch_queue.sv
// Directed bench for instruction_prefetch_queue with a behavioural fetch
// model feeding an expected-entry queue checked on every dequeue.
module tb_instruction_prefetch_queue;
  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_instruction;
  logic [31:0] out_pc_plus_four;
  logic        out_ready;
  logic [2:0]  occupancy;
  logic        state_dbg;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] exp_q[$];
  logic [31:0] model_pc     = 32'h0;
  logic [31:0] model_target = 32'h0;
  bit          discarding   = 1'b0;

  instruction_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clock           (clock),
    .reset           (reset),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .out_valid       (out_valid),
    .out_instruction (out_instruction),
    .out_pc_plus_four(out_pc_plus_four),
    .out_ready       (out_ready),
    .occupancy       (occupancy),
    .state_dbg       (state_dbg)
  );

  // Clock and memory contents
  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  task automatic check(input logic [63:0] obs, input logic [63:0] exp, input string tag);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic ack, input logic rdy, input logic redir, input logic [31:0] tgt);
    imem_ack    = ack;
    out_ready   = rdy;
    redirect    = redir;
    redirect_pc = tgt;
  endtask

  // Called at a falling edge after inputs are driven; models the coming rising edge.
  task automatic tick();
    logic [63:0] e;
    check(64'(occupancy), 64'(exp_q.size()), "occupancy");
    check(64'(out_valid), 64'(exp_q.size() != 0), "out_valid");
    if (imem_req) check(64'(imem_addr), 64'(model_pc), "imem_addr");
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check(64'(out_pc_plus_four), 64'hDEAD_0000_DEAD_0000, "pop_unexpected");
      end else begin
        e = exp_q.pop_front();
        check({out_instruction, out_pc_plus_four}, e, "pop_entry");
      end
    end
    if (redirect) begin
      exp_q.delete();
      if (imem_req && !imem_ack) begin
        discarding   = 1'b1;
        model_target = redirect_pc & 32'hFFFF_FFFC;
      end else begin
        discarding = 1'b0;
        model_pc   = redirect_pc & 32'hFFFF_FFFC;
      end
    end else if (imem_req && imem_ack) begin
      if (discarding) begin
        discarding = 1'b0;
        model_pc   = model_target;
      end else begin
        exp_q.push_back({mem_word(model_pc), model_pc + 32'd4});
        model_pc = model_pc + 32'd4;
      end
    end
    @(negedge clock);
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    check(64'(out_valid), 64'h0, "rst_out_valid");
    check(64'(occupancy), 64'h0, "rst_occupancy");
    check(64'(imem_req), 64'h0, "rst_imem_req");
    check(64'(out_instruction), 64'h0, "rst_out_instruction");
    check(64'(out_pc_plus_four), 64'h0, "rst_out_pc_plus_four");
    check(64'(state_dbg), 64'h0, "rst_state");
    @(negedge clock);
    reset = 1'b1;

    // Zero-wait streaming
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    check(64'(imem_req), 64'h1, "req_after_reset");
    check(64'(imem_addr), 64'h0, "first_addr");
    tick();
    check(64'(out_valid), 64'h1, "fill_valid");
    check(64'(out_pc_plus_four), 64'h4, "first_pc4");
    repeat (8) tick();

    // Back-pressure until full, then drain in order
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    repeat (10) tick();
    check(64'(imem_req), 64'h0, "req_drop_full");
    check(64'(occupancy), 64'd4, "occ_full");
    check(64'(out_pc_plus_four), 64'(exp_q[0][31:0]), "hold_head");
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    repeat (6) tick();

    // Delayed ack with a redirect while waiting
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    tick();
    drive(1'b0, 1'b1, 1'b1, 32'h40);
    tick();
    check(64'(state_dbg), 64'h1, "discard_state");
    check(64'(imem_req), 64'h1, "req_held");
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    tick();
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    check(64'(imem_addr), 64'h40, "redirect_addr");
    check(64'(state_dbg), 64'h0, "back_to_fetch");
    tick();
    check(64'(out_valid), 64'h1, "redirect_valid");
    check(64'(out_pc_plus_four), 64'h44, "redirect_pc4");

    // Redirect coinciding with ack and pop, unaligned target
    drive(1'b1, 1'b1, 1'b1, 32'h103);
    tick();
    check(64'(out_valid), 64'h0, "flush_valid");
    check(64'(occupancy), 64'h0, "flush_occ");
    check(64'(imem_addr), 64'h100, "aligned_target");
    check(64'(imem_req), 64'h1, "flush_req");
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    repeat (3) tick();

    // PC wrap at the top of the address space
    drive(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
    tick();
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    check(64'(out_valid), 64'h1, "wrap_valid");
    check(64'(out_pc_plus_four), 64'h0, "wrap_pc4");
    check(64'(imem_addr), 64'h0, "wrap_addr");
    repeat (2) tick();

    // Asynchronous reset mid-fill with a request outstanding
    drive(1'b1, 1'b0, 1'b1, 32'h200);
    tick();
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    repeat (3) tick();
    check(64'(occupancy), 64'd3, "pre_reset_occ");
    check(64'(imem_req), 64'h1, "pre_reset_req");
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    #2 reset = 1'b0;
    #1;
    check(64'(out_valid), 64'h0, "async_rst_valid");
    check(64'(occupancy), 64'h0, "async_rst_occ");
    check(64'(imem_req), 64'h0, "async_rst_req");
    exp_q.delete();
    model_pc   = 32'h0;
    discarding = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    check(64'(imem_req), 64'h1, "req_after_release");
    check(64'(imem_addr), 64'h0, "addr_after_release");
    tick();
    check(64'(out_pc_plus_four), 64'h4, "pc4_after_release");
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
